// File: rtl/phy_rgmii_rx_pkg.sv
// Shared RGMII receive definitions: FSM states, framing bytes and in-band status decode.
package eth_phy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [3:0] MAX_PREAMBLE  = 4'd7;

  // Idle nibble layout: bit0 link, bits2:1 speed, bit3 duplex.
  function automatic logic [3:0] inband_status(input logic [3:0] nib);
    return {nib[0], nib[2:1], nib[3]};
  endfunction

endpackage

// File: rtl/phy_rgmii_rx_if.sv
// Byte-side bundle between the IDDR capture stage and the RGMII receive decoder.
interface phy_rgmii_rx_if #(parameter int CNT_WIDTH = 16);
  logic [3:0]           rxd_rise_in;
  logic [3:0]           rxd_fall_in;
  logic                 rxctl_rise_in;
  logic                 rxctl_fall_in;
  logic [7:0]           phy_rxd_out;
  logic                 phy_rvalid_out;
  logic                 phy_rerr_out;
  logic                 sfd_seen_out;
  logic [3:0]           link_status_out;
  logic [CNT_WIDTH-1:0] frame_cnt_out;
  logic [CNT_WIDTH-1:0] err_cnt_out;

  modport master (
    output rxd_rise_in, rxd_fall_in, rxctl_rise_in, rxctl_fall_in,
    input  phy_rxd_out, phy_rvalid_out, phy_rerr_out, sfd_seen_out,
           link_status_out, frame_cnt_out, err_cnt_out
  );

  modport slave (
    input  rxd_rise_in, rxd_fall_in, rxctl_rise_in, rxctl_fall_in,
    output phy_rxd_out, phy_rvalid_out, phy_rerr_out, sfd_seen_out,
           link_status_out, frame_cnt_out, err_cnt_out
  );
endinterface

// File: rtl/phy_rgmii_rx_sync.sv
// Multi-stage synchroniser with asynchronous clear; output goes low at once, high STAGES edges later.
module sync_signal #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/phy_rgmii_rx.sv
// RGMII receive decoder: DDR sample pairs to bytes, frame delineation, in-band link status, frame stats.
module phy_rgmii_rx import eth_phy_pkg::*; #(
  parameter bit STRIP_PREAMBLE = 1'b0,
  parameter int CNT_WIDTH      = 16
) (
  input logic           phy_rx_clk,
  input logic           sys_rst_n,
  phy_rgmii_rx_if.slave rx
);

  logic                 w_rst_n;
  logic                 w_dv, w_er;
  logic [7:0]           w_byte;
  rx_state_e            r_state, w_state_nxt;
  logic [3:0]           r_pre_cnt, w_pre_cnt_nxt;
  logic                 w_frame_inc, w_err_inc, w_sfd;
  logic [7:0]           r_rxd;
  logic                 r_rvalid, r_rerr, r_sfd;
  logic [3:0]           r_link;
  logic [CNT_WIDTH-1:0] r_frame_cnt, r_err_cnt;

  // Assert passes straight through; release lands two clocks later, glitch-free.
  sync_signal #(.STAGES(2)) u_rst_sync (
    .i_clk   (phy_rx_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (1'b1),
    .o_q     (w_rst_n)
  );

  assign w_dv   = rx.rxctl_rise_in;
  assign w_er   = rx.rxctl_rise_in ^ rx.rxctl_fall_in;
  assign w_byte = {rx.rxd_fall_in, rx.rxd_rise_in};

  always_comb begin
    w_state_nxt   = r_state;
    w_pre_cnt_nxt = r_pre_cnt;
    w_frame_inc   = 1'b0;
    w_err_inc     = 1'b0;
    w_sfd         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_dv) begin
          if (w_er) begin
            w_state_nxt = ST_DROP;
          end else if (w_byte == PREAMBLE_BYTE) begin
            w_state_nxt   = ST_PREAMBLE;
            w_pre_cnt_nxt = 4'd1;
          end else if (w_byte == SFD_BYTE) begin
            w_state_nxt = ST_DATA;
            w_sfd       = 1'b1;
          end else begin
            w_state_nxt = ST_DROP;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!w_dv) begin
          w_state_nxt = ST_IDLE;
          w_err_inc   = 1'b1;
        end else if (w_er) begin
          w_state_nxt = ST_DROP;
        end else if (w_byte == SFD_BYTE) begin
          w_state_nxt = ST_DATA;
          w_sfd       = 1'b1;
        end else if (w_byte == PREAMBLE_BYTE) begin
          if (r_pre_cnt >= MAX_PREAMBLE) w_state_nxt   = ST_DROP;
          else                           w_pre_cnt_nxt = r_pre_cnt + 4'd1;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_DATA: begin
        // An error flagged on the closing cycle still spoils the frame.
        if (!w_dv) begin
          w_state_nxt = ST_IDLE;
          w_err_inc   = w_er;
          w_frame_inc = !w_er;
        end else if (w_er) begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!w_dv) begin
          w_state_nxt = ST_IDLE;
          w_err_inc   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge phy_rx_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_pre_cnt   <= '0;
      r_rxd       <= '0;
      r_rvalid    <= 1'b0;
      r_rerr      <= 1'b0;
      r_sfd       <= 1'b0;
      r_link      <= '0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre_cnt <= w_pre_cnt_nxt;
      r_rxd     <= w_byte;
      r_rerr    <= w_er;
      r_sfd     <= w_sfd;
      r_rvalid  <= STRIP_PREAMBLE ? (w_dv && r_state == ST_DATA) : w_dv;
      if (!w_dv && !w_er && rx.rxd_rise_in == rx.rxd_fall_in)
        r_link <= inband_status(rx.rxd_rise_in);
      if (w_frame_inc && r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
      if (w_err_inc && r_err_cnt != '1)     r_err_cnt   <= r_err_cnt + CNT_WIDTH'(1);
    end
  end

  assign rx.phy_rxd_out     = r_rxd;
  assign rx.phy_rvalid_out  = r_rvalid;
  assign rx.phy_rerr_out    = r_rerr;
  assign rx.sfd_seen_out    = r_sfd;
  assign rx.link_status_out = r_link;
  assign rx.frame_cnt_out   = r_frame_cnt;
  assign rx.err_cnt_out     = r_err_cnt;

endmodule

// File: tb/tb_phy_rgmii_rx.sv
// Scoreboard bench: pass-through, preamble-strip and narrow-counter instances share one RGMII stream.
module tb_phy_rgmii_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rxd_rise = '0, rxd_fall = '0;
  logic       ctl_rise = 1'b0, ctl_fall = 1'b0;
  logic [3:0] idle_nib = 4'h0;
  int         cyc = 0;
  int         n_cmp = 0, n_err = 0;
  bit         sb_en = 1'b0;
  int         v0 = 0, v1 = 0, s0 = 0, s1 = 0;
  int         exp_frm = 0, exp_err = 0;
  logic [63:0] q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  phy_rgmii_rx_if #(.CNT_WIDTH(16)) if0 ();
  phy_rgmii_rx_if #(.CNT_WIDTH(16)) if1 ();
  phy_rgmii_rx_if #(.CNT_WIDTH(3))  if2 ();

  assign if0.rxd_rise_in = rxd_rise;  assign if0.rxd_fall_in = rxd_fall;
  assign if0.rxctl_rise_in = ctl_rise; assign if0.rxctl_fall_in = ctl_fall;
  assign if1.rxd_rise_in = rxd_rise;  assign if1.rxd_fall_in = rxd_fall;
  assign if1.rxctl_rise_in = ctl_rise; assign if1.rxctl_fall_in = ctl_fall;
  assign if2.rxd_rise_in = rxd_rise;  assign if2.rxd_fall_in = rxd_fall;
  assign if2.rxctl_rise_in = ctl_rise; assign if2.rxctl_fall_in = ctl_fall;

  phy_rgmii_rx #(.STRIP_PREAMBLE(1'b0), .CNT_WIDTH(16)) u_dut0 (
    .phy_rx_clk(clk), .sys_rst_n(rst_n), .rx(if0.slave));
  phy_rgmii_rx #(.STRIP_PREAMBLE(1'b1), .CNT_WIDTH(16)) u_dut1 (
    .phy_rx_clk(clk), .sys_rst_n(rst_n), .rx(if1.slave));
  phy_rgmii_rx #(.STRIP_PREAMBLE(1'b0), .CNT_WIDTH(3)) u_dut2 (
    .phy_rx_clk(clk), .sys_rst_n(rst_n), .rx(if2.slave));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One DDR cycle; expected output stamped with the cycle it must appear in.
  task automatic drv(input logic dv, input logic er, input logic [7:0] b, input logic pay);
    @(negedge clk);
    rxd_rise = b[3:0];
    rxd_fall = b[7:4];
    ctl_rise = dv;
    ctl_fall = dv ^ er;
    if (sb_en) begin
      if (dv)  q0.push_back({23'd0, 32'(cyc + 1), er, b});
      if (pay) q1.push_back({23'd0, 32'(cyc + 1), er, b});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, {idle_nib, idle_nib}, 1'b0);
  endtask

  function automatic logic [7:0] rnd_pay();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h55 || b == 8'hD5) b = 8'h00;
    return b;
  endfunction

  task automatic frame(input int npre, input int npay, input int err_at, input bit hdr_ok);
    for (int i = 0; i < npre; i++) drv(1'b1, 1'b0, 8'h55, 1'b0);
    drv(1'b1, 1'b0, 8'hD5, 1'b0);
    for (int i = 0; i < npay; i++)
      drv(1'b1, (i == err_at), rnd_pay(), hdr_ok && (err_at < 0 || i <= err_at));
  endtask

  function automatic int sat3(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, "_frm0"}, 64'(if0.frame_cnt_out), 64'(exp_frm));
    chk({tag, "_err0"}, 64'(if0.err_cnt_out),   64'(exp_err));
    chk({tag, "_frm1"}, 64'(if1.frame_cnt_out), 64'(exp_frm));
    chk({tag, "_err1"}, 64'(if1.err_cnt_out),   64'(exp_err));
    chk({tag, "_frm2"}, 64'(if2.frame_cnt_out), 64'(sat3(exp_frm)));
    chk({tag, "_err2"}, 64'(if2.err_cnt_out),   64'(sat3(exp_err)));
    chk({tag, "_q0"}, 64'(q0.size()), 64'd0);
    chk({tag, "_q1"}, 64'(q1.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rxd"},  64'(if0.phy_rxd_out),     64'd0);
    chk({tag, "_vld"},  64'(if0.phy_rvalid_out),  64'd0);
    chk({tag, "_err"},  64'(if0.phy_rerr_out),    64'd0);
    chk({tag, "_sfd"},  64'(if0.sfd_seen_out),    64'd0);
    chk({tag, "_link"}, 64'(if0.link_status_out), 64'd0);
    chk({tag, "_frm"},  64'(if0.frame_cnt_out),   64'd0);
    chk({tag, "_ecnt"}, 64'(if0.err_cnt_out),     64'd0);
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      if (if0.phy_rvalid_out) begin
        v0++;
        if (q0.size() == 0) chk("d0_extra", {23'd0, 32'(cyc), if0.phy_rerr_out, if0.phy_rxd_out}, 64'd0);
        else chk("d0_byte", {23'd0, 32'(cyc), if0.phy_rerr_out, if0.phy_rxd_out}, q0.pop_front());
      end
      if (if1.phy_rvalid_out) begin
        v1++;
        if (q1.size() == 0) chk("d1_extra", {23'd0, 32'(cyc), if1.phy_rerr_out, if1.phy_rxd_out}, 64'd0);
        else chk("d1_byte", {23'd0, 32'(cyc), if1.phy_rerr_out, if1.phy_rxd_out}, q1.pop_front());
      end
      if (if0.sfd_seen_out) begin
        s0++;
        chk("sfd_align", 64'(if0.phy_rxd_out), 64'hD5);
      end
      if (if1.sfd_seen_out) s1++;
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    idle(4);
    sb_en = 1'b1;

    // Clean 7+1+64 frame
    v0 = 0; v1 = 0; s0 = 0; s1 = 0;
    frame(7, 64, -1, 1'b1);
    idle(3);
    exp_frm++;
    chk("t1_v0", 64'(v0), 64'd72);
    chk("t1_v1", 64'(v1), 64'd64);
    chk("t1_sfd0", 64'(s0), 64'd1);
    chk("t1_sfd1", 64'(s1), 64'd1);
    chk_cnt("t1");

    // Error on payload byte 10
    v1 = 0;
    frame(7, 20, 10, 1'b1);
    idle(3);
    exp_err++;
    chk("t2_v1", 64'(v1), 64'd11);
    chk_cnt("t2");

    // In-band link status
    idle_nib = 4'hD;
    idle(2);
    chk("link_d", 64'(if0.link_status_out), 64'hD);
    drv(1'b0, 1'b0, 8'h53, 1'b0);
    idle_nib = 4'h3;
    @(negedge clk);
    chk("link_hold", 64'(if0.link_status_out), 64'hD);
    idle(2);
    chk("link_3", 64'(if0.link_status_out), 64'hA);
    drv(1'b0, 1'b1, 8'h00, 1'b0);
    drv(1'b0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    chk("link_cext", 64'(if0.link_status_out), 64'hA);
    idle_nib = 4'hD;
    idle(2);
    chk_cnt("t3");

    // Over-long preamble dropped, then clean frame after one idle
    v1 = 0;
    frame(9, 8, -1, 1'b0);
    idle(1);
    frame(7, 8, -1, 1'b1);
    idle(3);
    exp_err++;
    exp_frm++;
    chk("t4_v1", 64'(v1), 64'd8);
    chk_cnt("t4");

    // Reset mid-payload
    frame(7, 20, -1, 1'b1);
    sb_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("mid");
    drv(1'b1, 1'b0, rnd_pay(), 1'b0);
    drv(1'b1, 1'b0, rnd_pay(), 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) drv(1'b1, 1'b0, rnd_pay(), 1'b0);
    idle(4);
    q0.delete();
    q1.delete();
    sb_en = 1'b1;
    exp_frm = 0;
    exp_err = 1;
    chk_cnt("t5a");
    frame(7, 16, -1, 1'b1);
    idle(3);
    exp_frm++;
    chk_cnt("t5b");

    // Saturation on the narrow instance
    for (int f = 0; f < 8; f++) begin
      frame(0, 2, -1, 1'b1);
      idle(1);
      exp_frm++;
      if (f == 5) begin
        idle(1);
        chk("sat_at7", 64'(if2.frame_cnt_out), 64'd7);
      end
    end
    for (int f = 0; f < 8; f++) begin
      drv(1'b1, 1'b0, 8'h11, 1'b0);
      drv(1'b1, 1'b0, 8'h22, 1'b0);
      idle(1);
      exp_err++;
    end
    idle(3);
    chk_cnt("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
